// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encodings,
// default operand width and counter sizing.
package seq_divider_pkg;
    localparam int DEF_WIDTH = 64;
    localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, dividend, divisor,
        input  quot, rem, busy, done, err
    );

    modport slave (
        input  start, dividend, divisor,
        output quot, rem, busy, done, err
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring step: shift a bit into the partial remainder and
// subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] r,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);
    logic [WIDTH:0] t;

    // r < divisor on entry, so the difference always fits back into WIDTH bits
    always_comb begin
        t      = {r, bit_in};
        q_bit  = (t >= {1'b0, divisor});
        r_next = q_bit ? (t[WIDTH-1:0] - divisor) : t[WIDTH-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// Sequential 2W/W restoring divider with overflow/divide-by-zero pre-check.
// Working registers are kept apart from the result registers so outputs hold during RUN.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;
    logic             ovf;

    logic [WIDTH-1:0] r_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r       (r),
        .bit_in  (q[WIDTH-1]),
        .divisor (dvsr),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    assign q_next = {q[WIDTH-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            r        <= '0;
            q        <= '0;
            dvsr     <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            bus.quot <= '0;
            bus.rem  <= '0;
            bus.err  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        dvsr     <= bus.divisor;
                        r        <= bus.dividend[2*WIDTH-1:WIDTH];
                        q        <= bus.dividend[WIDTH-1:0];
                        bus.busy <= 1'b1;
                        state    <= RUN;
                        // quotient would not fit (includes divisor 0): finish after one cycle
                        if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
                            ovf <= 1'b1;
                            cnt <= '0;
                        end else begin
                            ovf <= 1'b0;
                            cnt <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    if (ovf) begin
                        bus.quot <= '1;
                        bus.rem  <= q;
                        bus.err  <= 1'b1;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end else begin
                        r   <= r_next;
                        q   <= q_next;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            bus.quot <= q_next;
                            bus.rem  <= r_next;
                            bus.err  <= 1'b0;
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
